// File: rtl/comp_move_gen_pkg.sv
// rtl/comp_move_gen_pkg.sv - shared encodings, line table, state enum and cell priority
// Purpose: constants shared by the move generator, its interface and line evaluator.
//   Cell indexes in the tables are 0-based (0..8 for board cells 1..9).
package comp_move_gen_pkg;

  localparam logic [1:0] EMPTY    = 2'b00;
  localparam logic [1:0] PLAYER   = 2'b01;
  localparam logic [1:0] COMPUTER = 2'b10;

  // Rows, then columns, then the two diagonals; scan order decides "first line".
  localparam logic [3:0] LINE_TBL [0:7][0:2] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Fallback order when no win/block exists: centre, corners, edges.
  localparam logic [3:0] PRIO_TBL [0:8] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SELECT,
    ISSUE,
    WAIT_LOW
  } state_e;

endpackage

// File: rtl/comp_move_gen_if.sv
// rtl/comp_move_gen_if.sv - request/response bundle between game controller and move generator
// Ports: board[17:0], req, game_over (controller -> generator);
//        computer[3:0], comp, busy, no_move (generator -> controller).
interface comp_move_gen_if;
  logic [17:0] board;
  logic        req;
  logic        game_over;
  logic [3:0]  computer;
  logic        comp;
  logic        busy;
  logic        no_move;

  modport master (
    output board, req, game_over,
    input  computer, comp, busy, no_move
  );

  modport slave (
    input  board, req, game_over,
    output computer, comp, busy, no_move
  );
endinterface

// File: rtl/comp_move_gen_line_eval.sv
// rtl/comp_move_gen_line_eval.sv - classifies one three-cell line
// Ports: cell_a/b/c[1:0] in; two_comp, two_player, empty_pos[1:0] out.
//   empty_pos is only meaningful when two_comp or two_player is set.
module line_eval
  import comp_move_gen_pkg::*;
(
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  output logic       two_comp,
  output logic       two_player,
  output logic [1:0] empty_pos
);

  logic ea, eb, ec;

  assign ea = (cell_a == EMPTY);
  assign eb = (cell_b == EMPTY);
  assign ec = (cell_c == EMPTY);

  assign two_comp = (ec && cell_a == COMPUTER && cell_b == COMPUTER) ||
                    (eb && cell_a == COMPUTER && cell_c == COMPUTER) ||
                    (ea && cell_b == COMPUTER && cell_c == COMPUTER);

  assign two_player = (ec && cell_a == PLAYER && cell_b == PLAYER) ||
                      (eb && cell_a == PLAYER && cell_c == PLAYER) ||
                      (ea && cell_b == PLAYER && cell_c == PLAYER);

  assign empty_pos = ea ? 2'd0 : (eb ? 2'd1 : 2'd2);

endmodule

// File: rtl/comp_move_gen.sv
// rtl/comp_move_gen.sv - tic-tac-toe computer move generator
// Ports: clock, reset_n (async, active-low); bus (slave modport): board, req,
//   game_over in; computer (0-based cell), comp strobe, busy, no_move pulse out.
// One request: snapshot board, scan 8 lines (one per cycle), select, strobe.
module comp_move_gen
  import comp_move_gen_pkg::*;
(
  input logic            clock,
  input logic            reset_n,
  comp_move_gen_if.slave bus
);

  state_e      state_q, state_d;
  logic [17:0] snap_q, snap_d;
  logic [2:0]  idx_q, idx_d;
  logic        win_found_q, win_found_d;
  logic        blk_found_q, blk_found_d;
  logic [3:0]  win_cell_q, win_cell_d;
  logic [3:0]  blk_cell_q, blk_cell_d;
  logic [3:0]  computer_q, computer_d;
  logic        comp_q, comp_d;
  logic        no_move_q, no_move_d;

  logic [1:0]  cells [0:8];
  logic [3:0]  line_cells [0:2];
  logic        two_comp, two_player;
  logic [1:0]  empty_pos;
  logic [3:0]  empty_cell;
  logic        pick_valid;
  logic [3:0]  pick_cell;

  always_comb begin
    for (int i = 0; i < 9; i++) cells[i] = snap_q[2*i +: 2];
    for (int k = 0; k < 3; k++) line_cells[k] = LINE_TBL[idx_q][k];
  end

  line_eval u_line_eval (
    .cell_a     (cells[line_cells[0]]),
    .cell_b     (cells[line_cells[1]]),
    .cell_c     (cells[line_cells[2]]),
    .two_comp   (two_comp),
    .two_player (two_player),
    .empty_pos  (empty_pos)
  );

  always_comb begin
    case (empty_pos)
      2'd0:    empty_cell = line_cells[0];
      2'd1:    empty_cell = line_cells[1];
      default: empty_cell = line_cells[2];
    endcase
  end

  // Win/block cells came from empty snapshot cells, so they need no recheck.
  always_comb begin
    pick_valid = 1'b0;
    pick_cell  = 4'd0;
    if (win_found_q) begin
      pick_valid = 1'b1;
      pick_cell  = win_cell_q;
    end else if (blk_found_q) begin
      pick_valid = 1'b1;
      pick_cell  = blk_cell_q;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (!pick_valid && cells[PRIO_TBL[i]] == EMPTY) begin
          pick_valid = 1'b1;
          pick_cell  = PRIO_TBL[i];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    win_found_d = win_found_q;
    blk_found_d = blk_found_q;
    win_cell_d  = win_cell_q;
    blk_cell_d  = blk_cell_q;
    computer_d  = computer_q;
    comp_d      = 1'b0;
    no_move_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req && !bus.game_over) begin
          snap_d      = bus.board;
          win_found_d = 1'b0;
          blk_found_d = 1'b0;
          idx_d       = 3'd0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (two_comp && !win_found_q) begin
          win_found_d = 1'b1;
          win_cell_d  = empty_cell;
        end
        if (two_player && !blk_found_q) begin
          blk_found_d = 1'b1;
          blk_cell_d  = empty_cell;
        end
        // Index parks at 7 rather than wrapping.
        if (idx_q == 3'd7) state_d = SELECT;
        else               idx_d   = idx_q + 3'd1;
      end
      SELECT: begin
        if (pick_valid) begin
          computer_d = pick_cell;
          comp_d     = 1'b1;
          state_d    = ISSUE;
        end else begin
          no_move_d = 1'b1;
          state_d   = WAIT_LOW;
        end
      end
      ISSUE: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      snap_q      <= 18'd0;
      idx_q       <= 3'd0;
      win_found_q <= 1'b0;
      blk_found_q <= 1'b0;
      win_cell_q  <= 4'd0;
      blk_cell_q  <= 4'd0;
      computer_q  <= 4'd0;
      comp_q      <= 1'b0;
      no_move_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      win_found_q <= win_found_d;
      blk_found_q <= blk_found_d;
      win_cell_q  <= win_cell_d;
      blk_cell_q  <= blk_cell_d;
      computer_q  <= computer_d;
      comp_q      <= comp_d;
      no_move_q   <= no_move_d;
    end
  end

  assign bus.computer = computer_q;
  assign bus.comp     = comp_q;
  assign bus.no_move  = no_move_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: doc/comp_move_gen.md
COMP_MOVE_GEN -- requirements
Module: comp_move_gen

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: board  in  18  cell k (1..9) at bits [2k-1:2k-2]; 00 empty, 01 player, 10 computer, 11 treated as occupied.
REQ-004 SHALL have: req  in  1  level; request for one computer move.
REQ-005 SHALL have: game_over  in  1  level; win or board filled.
REQ-006 SHALL have: computer  out  4  chosen cell index, 0..8 for cells 1..9, registered.
REQ-007 SHALL have: comp  out  1  one-cycle move strobe, registered; computer valid while comp=1.
REQ-008 SHALL have: busy  out  1  high in every state except IDLE.
REQ-009 SHALL have: no_move  out  1  one-cycle pulse, no empty cell found.

Function
REQ-010 SHALL implement states IDLE, SCAN, SELECT, ISSUE, WAIT_LOW.
REQ-011 In IDLE, SHALL leave IDLE only on an edge sampling req=1 and game_over=0; at that edge it latches board into an internal snapshot, clears the win/block found flags, sets line index to 0, and enters SCAN.
REQ-012 In IDLE, req=1 with game_over=1 SHALL be ignored.
REQ-013 SCAN SHALL evaluate one line per cycle, index 0..7: rows {1,2,3},{4,5,6},{7,8,9}; columns {1,4,7},{2,5,8},{3,6,9}; diagonals {1,5,9},{3,5,7}.
REQ-014 A line with two computer marks and one empty cell SHALL record that empty cell as win cell, first line only.
REQ-015 A line with two player marks and one empty cell SHALL record that empty cell as block cell, first line only.
REQ-016 After line 7, SHALL enter SELECT; index SHALL NOT wrap back to 0 within the same request.
REQ-017 SELECT SHALL choose by priority: win cell; block cell; cell 5; corners 1,3,7,9 in that order; edges 2,4,6,8 in that order. Only empty cells qualify.
REQ-018 If a cell is chosen, SELECT SHALL register computer=cell-1 and enter ISSUE. Otherwise it SHALL pulse no_move, leave computer unchanged, and enter WAIT_LOW.
REQ-019 ISSUE SHALL drive comp=1 for exactly one cycle, then enter WAIT_LOW.
REQ-020 Latency SHALL be as follows: if req is sampled at edge E0, comp is high from edge E0+9 to edge E0+10.
REQ-021 computer SHALL hold its value until the next SELECT that chooses a cell.
REQ-022 WAIT_LOW SHALL return to IDLE on the first edge sampling req=0; a req held high SHALL NOT trigger a second move.
REQ-023 Board changes after the snapshot SHALL NOT affect the current decision.
REQ-024 game_over rising mid-operation SHALL NOT abort the operation; the integrating controller discards the strobe.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE, comp=0, no_move=0, busy=0, computer=4'd0, clear the snapshot, and clear the flags, regardless of state.
REQ-026 After reset_n deasserts, a req already high SHALL be treated as a new request at the first sampling edge.

Structure
REQ-027 A shared package SHALL hold: the cell encoding constants (EMPTY, PLAYER, COMPUTER); the 8x3 line-to-cell table; the state enum; and the priority order list for cells 5, corners and edges.
REQ-028 There SHALL be one combinational sub-module, line_eval. It takes three 2-bit cells and outputs two_comp, two_player, and the empty position 0..2.

Verification
REQ-029 Reset, empty board, req=1 at E0 -> comp=1 only in cycle E0+9, computer=4, busy high in E0..E0+10 until req drops.
REQ-030 Computer on cells 1,2; player on cells 4,5; req -> computer=2, because the win beats the block on cell 6.
REQ-031 Player on cells 1,2; computer on cell 5; req -> computer=2 (block).
REQ-032 Player on cell 5 only; req -> computer=0 (first corner); req held high 20 cycles -> exactly one comp pulse.
REQ-033 All cells occupied, game_over=0; req -> no_move one-cycle pulse at E0+9, comp stays 0, computer unchanged.
REQ-034 reset_n low at E0+4 mid-SCAN -> comp never asserts, outputs at reset values; req=1 at release -> a fresh full 9-cycle sequence.
